// File: rtl/oam_dma_bus_ctrl.sv
// CPU front-end bus controller with OAM DMA engine (main bus / high bus split).
// Optional build macro OAM_DMA_RESTART_EN: trigger writes restart a running transfer.
module oam_dma_bus_ctrl #(
    parameter int unsigned START_DELAY  = 4,
    parameter int unsigned DMA_LEN      = 160,
    parameter logic [15:0] OAM_BASE     = 16'hFE00,
    parameter logic [15:0] DMA_REG_ADDR = 16'hFF46
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    output logic [7:0]  cpu_rdata,
    output logic [15:0] main_addr,
    output logic [7:0]  main_wdata,
    output logic        main_we,
    input  logic [7:0]  main_rdata,
    output logic [15:0] hi_addr,
    output logic [7:0]  hi_wdata,
    output logic        hi_we,
    input  logic [7:0]  hi_rdata,
    output logic        dma_active
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RD,
        S_LATCH,
        S_WR
    } state_t;

    localparam logic [15:0] HI_BASE    = 16'hFF00;
    localparam logic [7:0]  DELAY_INIT = 8'(START_DELAY - 1);
    localparam logic [7:0]  LAST_IDX   = 8'(DMA_LEN - 1);

    state_t      fsm;
    logic [7:0]  cnt;
    logic [7:0]  dly;
    logic [7:0]  byte_q;
    logic [7:0]  src_q;
    logic [7:0]  src_map;
    logic        sel_q;
    logic        blk_q;
    logic        hi;
    logic        trig_wr;
    logic        trig;

    assign hi      = (cpu_addr >= HI_BASE);
    assign trig_wr = cpu_we && (cpu_addr == DMA_REG_ADDR);

`ifdef OAM_DMA_RESTART_EN
    assign trig = trig_wr;
`else
    assign trig = trig_wr && !dma_active;
`endif

    // Echo RAM pages fold back onto work RAM.
    assign src_map = (src_q >= 8'hE0) ? (src_q - 8'h20) : src_q;

    // High bus is always a straight pass-through of the CPU.
    assign hi_addr  = cpu_addr;
    assign hi_wdata = cpu_wdata;
    assign hi_we    = cpu_we && hi;

    // DMA sequencer: arm delay, then read / latch / write per byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm        <= S_IDLE;
            cnt        <= 8'h00;
            dly        <= 8'h00;
            byte_q     <= 8'h00;
            src_q      <= 8'h00;
            dma_active <= 1'b0;
        end else if (trig) begin
            fsm        <= S_ARM;
            dly        <= DELAY_INIT;
            src_q      <= cpu_wdata;
            cnt        <= 8'h00;
            dma_active <= 1'b1;
        end else begin
            unique case (fsm)
                S_IDLE: begin
                    fsm <= S_IDLE;
                end
                S_ARM: begin
                    if (dly == 8'h00) begin
                        fsm <= S_RD;
                    end else begin
                        dly <= dly - 8'h01;
                    end
                end
                S_RD: begin
                    fsm <= S_LATCH;
                end
                S_LATCH: begin
                    byte_q <= main_rdata;
                    fsm    <= S_WR;
                end
                S_WR: begin
                    if (cnt == LAST_IDX) begin
                        fsm        <= S_IDLE;
                        cnt        <= 8'h00;
                        dma_active <= 1'b0;
                    end else begin
                        cnt <= cnt + 8'h01;
                        fsm <= S_RD;
                    end
                end
                default: begin
                    fsm <= S_IDLE;
                end
            endcase
        end
    end

    // Remember where last cycle's read went and whether it was blocked.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q <= 1'b0;
            blk_q <= 1'b0;
        end else begin
            sel_q <= hi;
            blk_q <= dma_active && !hi;
        end
    end

    assign cpu_rdata = sel_q ? hi_rdata :
                       blk_q ? 8'hFF    : main_rdata;

    // Main bus owner: CPU while idle/arming, DMA during the copy phases.
    always_comb begin
        main_addr  = cpu_addr;
        main_wdata = cpu_wdata;
        main_we    = cpu_we && !hi && !dma_active;
        unique case (fsm)
            S_RD, S_LATCH: begin
                main_addr  = {src_map, cnt};
                main_wdata = byte_q;
                main_we    = 1'b0;
            end
            S_WR: begin
                main_addr  = OAM_BASE + {8'h00, cnt};
                main_wdata = byte_q;
                main_we    = 1'b1;
            end
            default: begin
                main_we = cpu_we && !hi && !dma_active;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma_bus_ctrl.sv
// Bench for oam_dma_bus_ctrl: bus memories, timeline model of the DMA,
// per-cycle compare plus directed scenario checks.
module tb_oam_dma_bus_ctrl;

    localparam int START = 4;
    localparam int LEN   = 160;
    localparam int TOTAL = START + 3 * LEN;
`ifdef OAM_DMA_RESTART_EN
    localparam bit RESTART = 1'b1;
`else
    localparam bit RESTART = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_we;
    logic [7:0]  cpu_rdata;
    logic [15:0] main_addr;
    logic [7:0]  main_wdata;
    logic        main_we;
    logic [7:0]  main_rdata;
    logic [15:0] hi_addr;
    logic [7:0]  hi_wdata;
    logic        hi_we;
    logic [7:0]  hi_rdata;
    logic        dma_active;

    oam_dma_bus_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_we     (cpu_we),
        .cpu_rdata  (cpu_rdata),
        .main_addr  (main_addr),
        .main_wdata (main_wdata),
        .main_we    (main_we),
        .main_rdata (main_rdata),
        .hi_addr    (hi_addr),
        .hi_wdata   (hi_wdata),
        .hi_we      (hi_we),
        .hi_rdata   (hi_rdata),
        .dma_active (dma_active)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ 8'h5A ^ (a[15:8] - 8'hC1);
    endfunction

    logic init_req;
    logic fill_req;

    // Bus memories seen by the DUT (1-cycle read latency).
    logic [7:0] mem  [0:65535];
    logic [7:0] hmem [0:255];

    always @(posedge clk) begin
        if (init_req) begin
            for (int a = 0; a < 65536; a++) mem[a] <= pat(16'(a));
            mem[16'hC000] <= 8'h33;
            for (int a = 0; a < 256; a++) hmem[a] <= 8'h00;
        end
        if (fill_req)
            for (int i = 0; i < LEN; i++) mem[16'hFE00 + 16'(i)] <= 8'hEE;
        if (main_we) mem[main_addr] <= main_wdata;
        if (hi_we) hmem[hi_addr[7:0]] <= hi_wdata;
        main_rdata <= mem[main_addr];
        hi_rdata   <= hmem[hi_addr[7:0]];
    end

    // Reference model: DMA timeline as cycles since the accepted trigger.
    logic [7:0] ref_mem [0:65535];
    logic [7:0] hi_ref  [0:255];
    bit         m_active = 1'b0;
    int         m_t = 0;
    logic [7:0] m_src = 8'h00;
    logic [7:0] exp_rd = 8'h00;
    bit         rd_ok = 1'b0;

    logic [15:0] e_addr;
    logic [7:0]  e_wdata;
    logic        e_we;
    int          e_j;
    logic [7:0]  e_k;
    logic [7:0]  e_sb;

    always_comb begin
        e_j     = 0;
        e_k     = 8'h00;
        e_sb    = 8'h00;
        e_addr  = cpu_addr;
        e_wdata = cpu_wdata;
        e_we    = cpu_we && (cpu_addr < 16'hFF00) && !m_active;
        if (m_active && m_t > START) begin
            e_j  = m_t - START - 1;
            e_k  = 8'(e_j / 3);
            e_sb = (m_src >= 8'hE0) ? m_src - 8'h20 : m_src;
            if (e_j % 3 == 2) begin
                e_addr  = 16'hFE00 + {8'h00, e_k};
                e_wdata = ref_mem[{e_sb, e_k}];
                e_we    = 1'b1;
            end else begin
                e_addr = {e_sb, e_k};
                e_we   = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (init_req) begin
            for (int a = 0; a < 65536; a++) ref_mem[a] = pat(16'(a));
            ref_mem[16'hC000] = 8'h33;
            for (int a = 0; a < 256; a++) hi_ref[a] = 8'h00;
        end
        if (rst) begin
            rd_ok = 1'b0;
        end else begin
            rd_ok = 1'b1;
            if (cpu_addr >= 16'hFF00) exp_rd = hi_ref[cpu_addr[7:0]];
            else if (m_active)        exp_rd = 8'hFF;
            else                      exp_rd = ref_mem[cpu_addr];
        end
        if (fill_req)
            for (int i = 0; i < LEN; i++) ref_mem[16'hFE00 + 16'(i)] = 8'hEE;
        if (e_we) ref_mem[e_addr] = e_wdata;
        if (cpu_we && cpu_addr >= 16'hFF00) hi_ref[cpu_addr[7:0]] = cpu_wdata;
        if (rst) begin
            m_active = 1'b0;
            m_t      = 0;
        end else if (cpu_we && cpu_addr == 16'hFF46 && (!m_active || RESTART)) begin
            m_active = 1'b1;
            m_t      = 1;
            m_src    = cpu_wdata;
        end else if (m_active) begin
            if (m_t == TOTAL) m_active = 1'b0;
            else m_t = m_t + 1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_cycle();
        if (!chk_en) return;
        chk("dma_active", 32'(dma_active), 32'(m_active));
        chk("main_we", 32'(main_we), 32'(e_we));
        chk("main_addr", 32'(main_addr), 32'(e_addr));
        if (e_we) chk("main_wdata", 32'(main_wdata), 32'(e_wdata));
        chk("hi_addr", 32'(hi_addr), 32'(cpu_addr));
        chk("hi_we", 32'(hi_we), 32'(cpu_we && cpu_addr >= 16'hFF00));
        if (hi_we) chk("hi_wdata", 32'(hi_wdata), 32'(cpu_wdata));
        if (rd_ok) chk("cpu_rdata", 32'(cpu_rdata), 32'(exp_rd));
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_addr  = 16'hFF80;
        cpu_wdata = 8'h00;
        cpu_we    = 1'b0;
    endtask

    task automatic fill_oam();
        fill_req = 1'b1;
        step(1);
        fill_req = 1'b0;
    endtask

    task automatic trigger(input logic [7:0] v);
        cpu_addr  = 16'hFF46;
        cpu_wdata = v;
        cpu_we    = 1'b1;
        @(negedge clk);
        chk("active_before_trigger", 32'(dma_active), 32'd0);
        step(1);
        idle();
    endtask

    task automatic chk_oam(input string nm, input logic [15:0] src, input int upto);
        for (int i = 0; i < LEN; i++)
            chk(nm, 32'(mem[16'hFE00 + 16'(i)]),
                32'((i < upto) ? pat(src + 16'(i)) : 8'hEE));
    endtask

    // Runs from cycle 1 after a trigger until dma_active drops.
    task automatic run_dma(input int mode, output int n);
        int c;
        bit done;
        c = 1;
        n = 0;
        done = 1'b0;
        while (!done && c < 3000) begin
            idle();
            rst = 1'b0;
            case (mode)
                1: begin
                    if (c == 20) cpu_addr = 16'hC000;
                    if (c == 22) begin
                        cpu_addr = 16'hC000; cpu_wdata = 8'h77; cpu_we = 1'b1;
                    end
                    if (c == 25) begin
                        cpu_addr = 16'hFF90; cpu_wdata = 8'hAB; cpu_we = 1'b1;
                    end
                    if (c == 26) cpu_addr = 16'hFF90;
                end
                3: if (c == 245) begin
                    cpu_addr = 16'hFF46; cpu_wdata = 8'hD0; cpu_we = 1'b1;
                end
                4: if (c == 155) rst = 1'b1;
                default: ;
            endcase
            @(negedge clk);
            case (mode)
                1: begin
                    if (c == 21) chk("blocked_read", 32'(cpu_rdata), 32'hFF);
                    if (c == 27) chk("hi_readback", 32'(cpu_rdata), 32'hAB);
                end
                2: if (c == 5) begin
                    chk("first_rd_addr", 32'(main_addr), 32'hC200);
                    chk("first_rd_we", 32'(main_we), 32'd0);
                end
                3: if (c == 246) chk("active_after_retrig", 32'(dma_active), 32'd1);
                default: ;
            endcase
            if (dma_active === 1'b1) n++;
            else done = 1'b1;
            step(1);
            c++;
        end
        chk("dma_done_in_budget", 32'(done), 32'd1);
        idle();
        rst = 1'b0;
    endtask

    int n;

    initial begin
        fork
            forever begin
                @(negedge clk);
                cmp_cycle();
            end
        join_none

        rst       = 1'b1;
        init_req  = 1'b1;
        fill_req  = 1'b0;
        cpu_addr  = 16'h1234;
        cpu_wdata = 8'h00;
        cpu_we    = 1'b0;
        step(1);
        init_req = 1'b0;
        step(2);
        rst    = 1'b0;
        chk_en = 1'b1;

        @(negedge clk);
        chk("reset_active", 32'(dma_active), 32'd0);
        chk("reset_main_we", 32'(main_we), 32'd0);
        chk("reset_hi_we", 32'(hi_we), 32'd0);
        chk("reset_main_addr", 32'(main_addr), 32'h1234);
        chk("reset_rdata", 32'(cpu_rdata), 32'h3F);
        step(1);

        // Plain copy from 0xC100 with CPU traffic interleaved.
        trigger(8'hC1);
        run_dma(1, n);
        chk("len_c1", 32'(n), 32'(TOTAL));
        chk_oam("oam_c1", 16'hC100, LEN);
        chk("oam_c1_first", 32'(mem[16'hFE00]), 32'h5A);
        chk("oam_c1_last", 32'(mem[16'hFE9F]), 32'hC5);
        cpu_addr = 16'hC000;
        step(1);
        idle();
        @(negedge clk);
        chk("c000_kept", 32'(cpu_rdata), 32'h33);
        chk("ff90_stored", 32'(hmem[8'h90]), 32'hAB);

        // Echo RAM source maps 0xE2 -> 0xC2.
        fill_oam();
        trigger(8'hE2);
        run_dma(2, n);
        chk("len_e2", 32'(n), 32'(TOTAL));
        chk_oam("oam_e2", 16'hC200, LEN);
        chk("oam_e2_first", 32'(mem[16'hFE00]), 32'h5B);

        // Reset during byte 50 leaves OAM partially written.
        fill_oam();
        trigger(8'hC1);
        run_dma(4, n);
        chk("len_reset", 32'(n), 32'd155);
        chk_oam("oam_partial", 16'hC100, 50);
        chk("oam_partial_49", 32'(mem[16'hFE31]), 32'h6B);
        chk("oam_partial_50", 32'(mem[16'hFE32]), 32'hEE);
        trigger(8'hC1);
        run_dma(0, n);
        chk("len_after_reset", 32'(n), 32'(TOTAL));
        chk_oam("oam_after_reset", 16'hC100, LEN);

        // Trigger write with source 0xD0 during byte 80.
        fill_oam();
        trigger(8'hC1);
        run_dma(3, n);
        chk("len_retrig", 32'(n), 32'(RESTART ? 245 + TOTAL : TOTAL));
        chk_oam("oam_retrig", RESTART ? 16'hD000 : 16'hC100, LEN);
        chk("oam_retrig_first", 32'(mem[16'hFE00]), 32'(RESTART ? 8'h55 : 8'h5A));
        chk("ff46_updated", 32'(hmem[8'h46]), 32'hD0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
